// File: rtl/exprnd_pipe.sv
// Registered exponent-round/overflow stage: packs final exponent/fraction behind a valid/ready register.
// Optional overflow flag and counter enabled by defining EXPRND_PIPE_FLAGS_EN.
module exprnd_pipe #(
    parameter int unsigned EW = 11,
    parameter int unsigned FW = 52,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          s,
    input  logic [EW-1:0] e3,
    input  logic [FW:0]   f3,
    input  logic [1:0]    rm,
    input  logic          ovf,
    input  logic          ovfen,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          s_out,
    output logic [EW-1:0] eout,
    output logic [FW-1:0] fout,
    output logic          ovf_out
`ifdef EXPRND_PIPE_FLAGS_EN
    ,
    input  logic          flag_clr,
    output logic          flag_ovf,
    output logic [CW-1:0] ovf_cnt
`endif
);

    // Trapped-overflow bias adjust: 3 * 2^(EW-2)
    localparam logic [EW-1:0] ALPHA   = {2'b11, {(EW-2){1'b0}}};
    localparam logic [EW-1:0] MAX_FIN = {{(EW-1){1'b1}}, 1'b0};

    logic          out_valid_q, out_valid_d;
    logic          s_out_q, s_out_d;
    logic [EW-1:0] eout_q, eout_d;
    logic [FW-1:0] fout_q, fout_d;
    logic          ovf_out_q, ovf_out_d;
    logic          accept;
    logic          inf;

    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign inf      = rm[1] ? ~(rm[0] ^ s) : rm[0];

    always_comb begin
        out_valid_d = accept | (out_valid_q & ~out_ready);
        s_out_d     = s_out_q;
        eout_d      = eout_q;
        fout_d      = fout_q;
        ovf_out_d   = ovf_out_q;
        if (accept) begin
            s_out_d   = s;
            ovf_out_d = ovf;
            fout_d    = f3[FW-1:0];
            if (ovf && ovfen) begin
                eout_d = EW'(e3 - ALPHA);
            end else if (ovf) begin
                // Untrapped overflow saturates to infinity or the largest finite value
                if (inf) begin
                    eout_d = '1;
                    fout_d = '0;
                end else begin
                    eout_d = MAX_FIN;
                    fout_d = '1;
                end
            end else begin
                eout_d = f3[FW] ? e3 : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            s_out_q     <= 1'b0;
            eout_q      <= '0;
            fout_q      <= '0;
            ovf_out_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            s_out_q     <= s_out_d;
            eout_q      <= eout_d;
            fout_q      <= fout_d;
            ovf_out_q   <= ovf_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign s_out     = s_out_q;
    assign eout      = eout_q;
    assign fout      = fout_q;
    assign ovf_out   = ovf_out_q;

`ifdef EXPRND_PIPE_FLAGS_EN
    logic          flag_ovf_q, flag_ovf_d;
    logic [CW-1:0] ovf_cnt_q, ovf_cnt_d;

    // Set/increment takes priority over a same-cycle clear
    always_comb begin
        flag_ovf_d = flag_ovf_q;
        ovf_cnt_d  = ovf_cnt_q;
        if (accept && ovf) begin
            flag_ovf_d = 1'b1;
            if (ovf_cnt_q != {CW{1'b1}}) begin
                ovf_cnt_d = ovf_cnt_q + CW'(1);
            end
        end else if (flag_clr) begin
            flag_ovf_d = 1'b0;
            ovf_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_ovf_q <= 1'b0;
            ovf_cnt_q  <= '0;
        end else begin
            flag_ovf_q <= flag_ovf_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    assign flag_ovf = flag_ovf_q;
    assign ovf_cnt  = ovf_cnt_q;
`endif

endmodule
